axis_to_i2s_mc: RTL and testbench



---
 rtl/axis_to_i2s_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_axis_to_i2s_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_i2s_mc.sv
// axis_to_i2s_mc: multi-lane I2S / left-justified transmitter.
// Tagged AXI4-Stream samples are assembled into whole frames and queued in a
// frame FIFO. The frames are then shifted out on NUM_PAIRS data lanes that
// share one SCLK/LRCLK pair. Everything runs on aud_mclk.
module axis_to_i2s_mc #(
    parameter int NUM_PAIRS  = 4,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int MCLK_DIV   = 4
) (
    input  logic                               aud_mclk,
    input  logic                               aud_mrst,
    input  logic                               enable,
    input  logic                               mode,
    input  logic [31:0]                        s_axis_aud_tdata,
    input  logic [2:0]                         s_axis_aud_tid,
    input  logic                               s_axis_aud_tvalid,
    output logic                               s_axis_aud_tready,
    output logic                               lrclk_out,
    output logic                               sclk_out,
    output logic [NUM_PAIRS-1:0]               sdata_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               underrun,
    output logic                               err_tid
);

    localparam int NCH     = 2 * NUM_PAIRS;
    localparam int FRAME_W = NCH * DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = $clog2(MCLK_DIV);
    localparam logic [2:0] LAST_CH = 3'(NCH - 1);

    // ------------------------------------------------------------------
    // Frame assembler
    // ------------------------------------------------------------------
    logic [2:0]          exp_reg, exp_next;
    logic                err_reg;
    logic                beat_hs, tid_match, store, push;
    logic [DATA_W-1:0]   beat_sample;
    logic [DATA_W-1:0]   asm_reg [NCH-1];
    logic [FRAME_W-1:0]  push_frame;
    logic                unused_tdata;

    // FIFO state (declared early: tready depends on fullness)
    logic [FRAME_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]    level_reg;
    logic                fifo_full, fifo_empty, pop;
    logic [FRAME_W-1:0]  rd_frame;

    assign beat_sample  = s_axis_aud_tdata[31 -: DATA_W];
    assign unused_tdata = ^s_axis_aud_tdata;
    assign fifo_full    = (level_reg == LVL_W'(FIFO_DEPTH));
    assign fifo_empty   = (level_reg == '0);

    // Only the last beat of a frame can stall; a same-cycle pop does not help.
    assign s_axis_aud_tready = !aud_mrst && !((exp_reg == LAST_CH) && fifo_full);

    assign beat_hs   = s_axis_aud_tvalid && s_axis_aud_tready;
    assign tid_match = (s_axis_aud_tid == exp_reg);
    // A mismatching tid 0 restarts the frame, so the stored index is always tid.
    assign store     = beat_hs && (tid_match || (s_axis_aud_tid == 3'd0));
    assign push      = beat_hs && tid_match && (exp_reg == LAST_CH);

    // Next expected channel index
    always_comb begin
        exp_next = exp_reg;
        if (beat_hs) begin
            if (tid_match)
                exp_next = (exp_reg == LAST_CH) ? 3'd0 : exp_reg + 3'd1;
            else if (s_axis_aud_tid == 3'd0)
                exp_next = 3'd1;
            else
                exp_next = 3'd0;
        end
    end

    // Expected-index register and sequence-error pulse
    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            exp_reg <= 3'd0;
            err_reg <= 1'b0;
        end else begin
            exp_reg <= exp_next;
            err_reg <= beat_hs && !tid_match;
        end
    end

    // Holding registers for every channel except the last, which goes straight to the FIFO
    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            for (int i = 0; i < NCH - 1; i++) asm_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NCH - 1; i++)
                if (store && (s_axis_aud_tid == 3'(i))) asm_reg[i] <= beat_sample;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_pack
            if (gi == NCH - 1) begin : g_last
                assign push_frame[gi*DATA_W +: DATA_W] = beat_sample;
            end else begin : g_held
                assign push_frame[gi*DATA_W +: DATA_W] = asm_reg[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    assign rd_frame   = mem[rd_ptr_reg];
    assign fifo_level = level_reg;

    // Frame storage write port
    always_ff @(posedge aud_mclk) begin
        if (push) mem[wr_ptr_reg] <= push_frame;
    end

    // Pointers and occupancy
    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit-clock divider and bit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [5:0]       bitc_reg, bitc_next;
    logic             run_reg, first_cyc, cnt_wrap, fall_tick, frame_load;
    logic             sclk_reg, underrun_reg, mode_reg, eff_mode;

    assign first_cyc  = enable && !run_reg;
    assign cnt_wrap   = (cnt_reg == CNT_W'(MCLK_DIV - 1));
    assign fall_tick  = enable && (first_cyc || cnt_wrap);
    assign frame_load = first_cyc || (fall_tick && (bitc_reg == 6'd63));
    assign pop        = frame_load && !fifo_empty;
    assign eff_mode   = frame_load ? mode : mode_reg;

    // Divider / bit counter next state; the first enabled cycle behaves as a wrap
    always_comb begin
        cnt_next  = cnt_reg;
        bitc_next = bitc_reg;
        if (!enable) begin
            cnt_next  = '0;
            bitc_next = 6'd0;
        end else if (first_cyc) begin
            cnt_next  = '0;
            bitc_next = 6'd0;
        end else if (cnt_wrap) begin
            cnt_next  = '0;
            bitc_next = bitc_reg + 6'd1;
        end else begin
            cnt_next  = cnt_reg + CNT_W'(1);
        end
    end

    // Timing registers, SCLK, underrun pulse and latched framing mode
    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            run_reg      <= 1'b0;
            cnt_reg      <= '0;
            bitc_reg     <= 6'd0;
            sclk_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            mode_reg     <= 1'b0;
        end else begin
            run_reg      <= enable;
            cnt_reg      <= cnt_next;
            bitc_reg     <= bitc_next;
            sclk_reg     <= enable && (cnt_next >= CNT_W'(MCLK_DIV / 2));
            underrun_reg <= frame_load && fifo_empty;
            mode_reg     <= eff_mode;
        end
    end

    assign sclk_out  = sclk_reg;
    assign lrclk_out = bitc_reg[5];
    assign underrun  = underrun_reg;
    assign err_tid   = err_reg;

    // ------------------------------------------------------------------
    // Per-lane serializers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_lane
            logic [63:0] load_word;
            logic [63:0] shift_reg;
            logic        lj_bit, dly_reg, sd_reg;

            // Left sample in the top slot, right in the bottom slot, zero padded
            always_comb begin
                load_word = '0;
                if (!fifo_empty) begin
                    load_word[63 -: DATA_W] = rd_frame[(2*gi)*DATA_W +: DATA_W];
                    load_word[31 -: DATA_W] = rd_frame[(2*gi+1)*DATA_W +: DATA_W];
                end
            end

            assign lj_bit = frame_load ? load_word[63] : shift_reg[63];

            // Shift on fall ticks; I2S output lags the left-justified bit by one tick
            always_ff @(posedge aud_mclk) begin
                if (aud_mrst) begin
                    shift_reg <= '0;
                    dly_reg   <= 1'b0;
                    sd_reg    <= 1'b0;
                end else if (!enable) begin
                    dly_reg   <= 1'b0;
                    sd_reg    <= 1'b0;
                end else if (fall_tick) begin
                    shift_reg <= (frame_load ? load_word : shift_reg) << 1;
                    dly_reg   <= lj_bit;
                    sd_reg    <= eff_mode ? lj_bit : dly_reg;
                end
            end

            assign sdata_out[gi] = sd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_axis_to_i2s_mc.sv
// Directed bench for axis_to_i2s_mc (4 lanes, 24-bit samples, depth 8, MCLK_DIV 4).
`timescale 1ns/1ps
module tb_axis_to_i2s_mc;

    localparam int NP = 4;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          srst;
    logic          enable;
    logic          mode;
    logic [31:0]   tdata;
    logic [2:0]    tid;
    logic          tvalid;
    logic          tready;
    logic          lrclk;
    logic          sclk;
    logic [NP-1:0] sdata;
    logic [3:0]    level;
    logic          underrun;
    logic          err_tid;

    axis_to_i2s_mc #(
        .NUM_PAIRS  (NP),
        .DATA_W     (DW),
        .FIFO_DEPTH (8),
        .MCLK_DIV   (4)
    ) dut (
        .aud_mclk          (clk),
        .aud_mrst          (srst),
        .enable            (enable),
        .mode              (mode),
        .s_axis_aud_tdata  (tdata),
        .s_axis_aud_tid    (tid),
        .s_axis_aud_tvalid (tvalid),
        .s_axis_aud_tready (tready),
        .lrclk_out         (lrclk),
        .sclk_out          (sclk),
        .sdata_out         (sdata),
        .fifo_level        (level),
        .underrun          (underrun),
        .err_tid           (err_tid)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int err_cnt = 0;
    int und_cnt = 0;

    logic [31:0] fr [8];
    logic [63:0] cap [NP];
    logic [63:0] cap_lr;
    logic [63:0] cap_sclk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (err_tid)  err_cnt <= err_cnt + 1;
        if (underrun) und_cnt <= und_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] lane_word(input logic [31:0] l, input logic [31:0] r);
        logic [63:0] w;
        w = '0;
        w[63 -: DW] = l[31 -: DW];
        w[31 -: DW] = r[31 -: DW];
        return w;
    endfunction

    // One beat; called on a negedge, returns on the negedge after the handshake
    task automatic send_beat(input logic [2:0] t, input logic [31:0] d);
        int n;
        n = 0;
        tid = t; tdata = d; tvalid = 1'b1;
        while (!tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready", 64'(tready), 64'd1);
        @(negedge clk);
        tvalid = 1'b0;
        $display("beat tid=%0d data=%08h level=%0d", t, d, level);
    endtask

    task automatic push_frame();
        for (int c = 0; c < 8; c++) send_beat(3'(c), fr[c]);
    endtask

    // Called on the negedge just before a frame-load edge; samples each bit while SCLK is high
    task automatic capture_frame();
        repeat (3) @(negedge clk);
        for (int n = 0; n < 64; n++) begin
            for (int k = 0; k < NP; k++) cap[k][63-n] = sdata[k];
            cap_lr[63-n]   = lrclk;
            cap_sclk[63-n] = sclk;
            if (n != 63) repeat (4) @(negedge clk);
        end
        $display("frame lane0=%016h lrclk=%016h", cap[0], cap_lr);
    endtask

    initial begin
        int u0, e0, c0, bad;
        srst = 1'b1; enable = 1'b0; mode = 1'b0;
        tvalid = 1'b0; tid = 3'd0; tdata = 32'd0;
        fr[0] = 32'hABCDEF00; fr[1] = 32'h12345600;
        fr[2] = 32'h778899FF; fr[3] = 32'h0A0B0C00;
        fr[4] = 32'h5A5A5A00; fr[5] = 32'hA5A5A500;
        fr[6] = 32'h00000100; fr[7] = 32'hFFFFFF00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready",   64'(tready),   64'd0);
        check("rst_sclk",     64'(sclk),     64'd0);
        check("rst_lrclk",    64'(lrclk),    64'd0);
        check("rst_sdata",    64'(sdata),    64'd0);
        check("rst_level",    64'(level),    64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_err",      64'(err_tid),  64'd0);
        srst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 64'(tready), 64'd1);

        // I2S frame
        push_frame();
        check("i2s_level_after_push", 64'(level), 64'd1);
        u0 = und_cnt;
        mode = 1'b0; enable = 1'b1;
        capture_frame();
        check("i2s_lane0", cap[0], 64'h55E6F780_091A2B00);
        for (int k = 1; k < NP; k++)
            check($sformatf("i2s_lane%0d", k), cap[k], lane_word(fr[2*k], fr[2*k+1]) >> 1);
        check("i2s_lrclk", cap_lr, 64'h00000000_FFFFFFFF);
        check("i2s_sclk_high", cap_sclk, 64'hFFFFFFFF_FFFFFFFF);
        check("i2s_level_popped", 64'(level), 64'd0);
        check("i2s_no_underrun", 64'(und_cnt - u0), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        check("dis_sdata", 64'(sdata), 64'd0);
        check("dis_sclk",  64'(sclk),  64'd0);
        check("dis_lrclk", 64'(lrclk), 64'd0);

        // Left-justified frame
        mode = 1'b1;
        push_frame();
        enable = 1'b1;
        capture_frame();
        check("lj_lane0", cap[0], 64'hABCDEF00_12345600);
        for (int k = 1; k < NP; k++)
            check($sformatf("lj_lane%0d", k), cap[k], lane_word(fr[2*k], fr[2*k+1]));
        enable = 1'b0;
        @(negedge clk);

        // Sequence error: 0, 2, then a full frame starting again at 0
        e0 = err_cnt;
        send_beat(3'd0, 32'h11111100);
        send_beat(3'd2, 32'h22222200);
        check("seq_level_after_err", 64'(level), 64'd0);
        send_beat(3'd0, 32'hCAFEBA00);
        for (int c = 1; c < 7; c++) send_beat(3'(c), fr[c]);
        check("seq_level_before_last", 64'(level), 64'd0);
        send_beat(3'd7, fr[7]);
        check("seq_level_after_last", 64'(level), 64'd1);
        @(negedge clk);
        check("seq_err_pulses", 64'(err_cnt - e0), 64'd1);
        enable = 1'b1;
        capture_frame();
        check("seq_lane0", cap[0], 64'hCAFEBA00_12345600);
        enable = 1'b0;
        @(negedge clk);

        // Underrun with an empty FIFO, then one frame pushed mid-frame
        u0 = und_cnt;
        c0 = cyc;
        bad = 0;
        enable = 1'b1;
        while (cyc < c0 + 290) begin
            @(negedge clk);
            if (sdata !== '0) bad++;
        end
        check("und_zero_data", 64'(bad), 64'd0);
        fr[0] = 32'h13579B00;
        push_frame();
        check("und_level_queued", 64'(level), 64'd1);
        while (cyc < c0 + 512) @(negedge clk);
        check("und_pulses", 64'(und_cnt - u0), 64'd2);
        capture_frame();
        check("und_next_frame_lane0", cap[0], 64'h13579B00_12345600);
        check("und_pulses_after_data", 64'(und_cnt - u0), 64'd2);
        enable = 1'b0;
        @(negedge clk);

        // Back-pressure: fill 8 frames, stall the 9th at its last beat
        for (int f = 0; f < 8; f++) begin
            fr[0] = {8'(f + 1), 24'h00_0000};
            push_frame();
        end
        check("bp_level_full", 64'(level), 64'd8);
        for (int c = 0; c < 7; c++) send_beat(3'(c), fr[c]);
        tid = 3'd7; tdata = fr[7]; tvalid = 1'b1;
        check("bp_tready_last_low", 64'(tready), 64'd0);
        repeat (3) @(negedge clk);
        check("bp_tready_held_low", 64'(tready), 64'd0);
        check("bp_level_held", 64'(level), 64'd8);
        enable = 1'b1;
        check("bp_tready_pop_cycle", 64'(tready), 64'd0);
        @(negedge clk);
        check("bp_tready_after_pop", 64'(tready), 64'd1);
        @(negedge clk);
        tvalid = 1'b0;
        check("bp_level_refilled", 64'(level), 64'd8);

        // Mid-frame reset with 3 frames queued
        enable = 1'b0;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        check("mr_level_cleared", 64'(level), 64'd0);
        for (int f = 0; f < 3; f++) push_frame();
        check("mr_level_three", 64'(level), 64'd3);
        c0 = cyc;
        enable = 1'b1;
        while (cyc < c0 + 162) @(negedge clk);
        check("mr_lrclk_before", 64'(lrclk), 64'd1);
        check("mr_level_before", 64'(level), 64'd2);
        srst = 1'b1;
        @(negedge clk);
        check("mr_sclk",   64'(sclk),   64'd0);
        check("mr_lrclk",  64'(lrclk),  64'd0);
        check("mr_sdata",  64'(sdata),  64'd0);
        check("mr_level",  64'(level),  64'd0);
        check("mr_tready", 64'(tready), 64'd0);
        srst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("mr_tready_release", 64'(tready), 64'd1);
        check("mr_level_release",  64'(level),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
